// File: rtl/w_buffer_loader_if.sv
// Bus bundle of the weight loader: BRAM read port toward the staging memory and
// the per-column RAM write port toward the weight buffer.
interface w_buffer_loader_if #(
    parameter int ADDR_WIDTH      = 8,
    parameter int ARRAY_M         = 8,
    parameter int WGT_WIDTH       = 8,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 16
);
    logic                       bram_en;
    logic [BRAM_ADDR_WIDTH-1:0] bram_addr;
    logic [BRAM_DATA_WIDTH-1:0] bram_rdata;
    logic [ARRAY_M-1:0]         bram_to_ram_w_en;
    logic [ADDR_WIDTH-1:0]      bram_to_ram_w_addr;
    logic [WGT_WIDTH-1:0]       bram_to_ram_w_data;

    modport master (
        output bram_en, bram_addr,
        input  bram_rdata,
        output bram_to_ram_w_en, bram_to_ram_w_addr, bram_to_ram_w_data
    );

    modport slave (
        input  bram_en, bram_addr,
        output bram_rdata,
        input  bram_to_ram_w_en, bram_to_ram_w_addr, bram_to_ram_w_data
    );
endinterface

// File: rtl/w_buffer_loader.sv
// Streams packed weight words from BRAM into the column RAMs of the weight
// buffer, one weight per cycle, column-major, with all outputs registered.
module w_buffer_loader #(
    parameter int RAM_SIZE        = 256,
    parameter int ADDR_WIDTH      = $clog2(RAM_SIZE),
    parameter int ARRAY_M         = 8,
    parameter int WGT_WIDTH       = 8,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 16,
    parameter int BPW             = BRAM_DATA_WIDTH / WGT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BRAM_ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0]      dst_base,
    input  logic [$clog2(ARRAY_M):0]   num_cols,
    input  logic [ADDR_WIDTH:0]        depth,
    output logic                       busy,
    output logic                       done,
    w_buffer_loader_if.master          bus
);
    localparam int NCOL_W = $clog2(ARRAY_M) + 1;
    localparam int COL_W  = (ARRAY_M > 1) ? $clog2(ARRAY_M) : 1;
    localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TOT_W  = NCOL_W + ADDR_WIDTH + 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_UNPACK, S_DONE} state_t;
    typedef logic [BPW-1:0][WGT_WIDTH-1:0] word_t;

    state_t                     state_q, state_d;
    logic                       busy_q, busy_d, done_q, done_d;
    logic                       bram_en_q, bram_en_d;
    logic [BRAM_ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [ARRAY_M-1:0]         w_en_q, w_en_d;
    logic [ADDR_WIDTH-1:0]      w_addr_q, w_addr_d;
    logic [WGT_WIDTH-1:0]       w_data_q, w_data_d;
    logic [ADDR_WIDTH-1:0]      dst_q, dst_d;
    logic [ADDR_WIDTH-1:0]      depth_last_q, depth_last_d;
    logic [TOT_W-1:0]           rem_q, rem_d;
    logic [ADDR_WIDTH-1:0]      row_q, row_d;
    logic [COL_W-1:0]           col_q, col_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    word_t                      word_q, word_d;

    word_t                      rdata_lanes;
    logic [NCOL_W-1:0]          ncol_in;
    logic                       empty_req, last_elem, lane_end, row_wrap;
    logic [ADDR_WIDTH-1:0]      row_adv;
    logic [COL_W-1:0]           col_adv;
    logic [LANE_W-1:0]          lane_adv;

    assign rdata_lanes = bus.bram_rdata;
    assign ncol_in     = (num_cols > NCOL_W'(ARRAY_M)) ? NCOL_W'(ARRAY_M) : num_cols;
    assign empty_req   = (ncol_in == '0) || (depth == '0);
    // rem_q counts the element currently on the write port plus those still to come.
    assign last_elem   = (rem_q == TOT_W'(1));
    assign lane_end    = (lane_q == LANE_W'(BPW - 1));
    assign row_wrap    = (row_q == depth_last_q);
    assign row_adv     = row_wrap ? '0 : row_q + ADDR_WIDTH'(1);
    assign col_adv     = row_wrap ? col_q + COL_W'(1) : col_q;
    assign lane_adv    = lane_q + LANE_W'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = empty_req ? S_DONE : S_FETCH;
            S_FETCH:  state_d = S_WAIT;
            S_WAIT:   state_d = S_UNPACK;
            S_UNPACK: begin
                if (last_elem)     state_d = S_DONE;
                else if (lane_end) state_d = S_FETCH;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d       = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_UNPACK);
        done_d       = (state_d == S_DONE);
        bram_en_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        w_en_d       = '0;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        dst_d        = dst_q;
        depth_last_d = depth_last_q;
        rem_d        = rem_q;
        row_d        = row_q;
        col_d        = col_q;
        lane_d       = lane_q;
        word_d       = word_q;
        case (state_q)
            S_IDLE: begin
                if (start && !empty_req) begin
                    bram_en_d    = 1'b1;
                    bram_addr_d  = src_base;
                    dst_d        = dst_base;
                    depth_last_d = ADDR_WIDTH'(depth - 1'b1);
                    rem_d        = TOT_W'(ncol_in) * TOT_W'(depth);
                    row_d        = '0;
                    col_d        = '0;
                    lane_d       = '0;
                end
            end
            S_WAIT: begin
                word_d   = rdata_lanes;
                w_en_d   = ARRAY_M'(1) << col_q;
                w_addr_d = dst_q + row_q;
                w_data_d = rdata_lanes[0];
            end
            S_UNPACK: begin
                if (!last_elem) begin
                    row_d = row_adv;
                    col_d = col_adv;
                    rem_d = rem_q - TOT_W'(1);
                    if (lane_end) begin
                        lane_d      = '0;
                        bram_en_d   = 1'b1;
                        bram_addr_d = bram_addr_q + BRAM_ADDR_WIDTH'(1);
                    end else begin
                        lane_d   = lane_adv;
                        w_en_d   = ARRAY_M'(1) << col_adv;
                        w_addr_d = dst_q + row_adv;
                        w_data_d = word_q[lane_adv];
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: the word register is an ordinary flop bank, not a memory, so it is
    // reset along with everything else and a load always starts from a clean state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bram_en_q    <= 1'b0;
            bram_addr_q  <= '0;
            w_en_q       <= '0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            dst_q        <= '0;
            depth_last_q <= '0;
            rem_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            lane_q       <= '0;
            word_q       <= '0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            bram_en_q    <= bram_en_d;
            bram_addr_q  <= bram_addr_d;
            w_en_q       <= w_en_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            dst_q        <= dst_d;
            depth_last_q <= depth_last_d;
            rem_q        <= rem_d;
            row_q        <= row_d;
            col_q        <= col_d;
            lane_q       <= lane_d;
            word_q       <= word_d;
        end
    end

    assign busy                   = busy_q;
    assign done                   = done_q;
    assign bus.bram_en            = bram_en_q;
    assign bus.bram_addr          = bram_addr_q;
    assign bus.bram_to_ram_w_en   = w_en_q;
    assign bus.bram_to_ram_w_addr = w_addr_q;
    assign bus.bram_to_ram_w_data = w_data_q;
endmodule

// File: tb/tb_w_buffer_loader.sv
// Self-checking bench for w_buffer_loader: directed scenarios plus random loads,
// compared cycle by cycle against an element-indexed reference model.
module tb_w_buffer_loader;
    localparam int ADDR_WIDTH = 8;
    localparam int ARRAY_M    = 8;
    localparam int WGT_WIDTH  = 8;
    localparam int BDW        = 32;
    localparam int BAW        = 16;
    localparam int BPW        = BDW / WGT_WIDTH;
    localparam int MAXC       = 1024;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [BAW-1:0] src_base = '0;
    logic [7:0]     dst_base = '0;
    logic [3:0]     num_cols = '0;
    logic [8:0]     depth = '0;
    logic           busy, done;

    int n_checks = 0;
    int n_errors = 0;

    w_buffer_loader_if #(
        .ADDR_WIDTH(ADDR_WIDTH), .ARRAY_M(ARRAY_M), .WGT_WIDTH(WGT_WIDTH),
        .BRAM_DATA_WIDTH(BDW), .BRAM_ADDR_WIDTH(BAW)
    ) bus ();

    w_buffer_loader #(
        .RAM_SIZE(256), .ADDR_WIDTH(ADDR_WIDTH), .ARRAY_M(ARRAY_M), .WGT_WIDTH(WGT_WIDTH),
        .BRAM_DATA_WIDTH(BDW), .BRAM_ADDR_WIDTH(BAW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .src_base(src_base), .dst_base(dst_base),
        .num_cols(num_cols), .depth(depth), .busy(busy), .done(done), .bus(bus.master)
    );

    always #5 clk = ~clk;

    logic [BDW-1:0] mem [0:65535];

    always @(posedge clk) begin
        if (bus.bram_en) bus.bram_rdata <= mem[bus.bram_addr];
    end

    // Expected per-cycle activity; cycle 1 is the cycle right after start is sampled.
    logic           exp_ben   [MAXC];
    logic [BAW-1:0] exp_baddr [MAXC];
    logic [7:0]     exp_wen   [MAXC];
    logic [7:0]     exp_waddr [MAXC];
    logic [7:0]     exp_wdata [MAXC];
    int             exp_done_cyc;
    int             exp_total;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic build_model(input logic [BAW-1:0] s, input logic [7:0] d,
                               input int nc, input int dp);
        int ncl, j, lane, fc, wc, last;
        logic [BAW-1:0] waddr;
        logic [BDW-1:0] word;
        for (int c = 0; c < MAXC; c++) begin
            exp_ben[c] = 1'b0; exp_baddr[c] = '0; exp_wen[c] = '0;
            exp_waddr[c] = '0; exp_wdata[c] = '0;
        end
        ncl = (nc > ARRAY_M) ? ARRAY_M : nc;
        exp_total = ncl * dp;
        last = 0;
        for (int k = 0; k < exp_total; k++) begin
            j     = k / BPW;
            lane  = k % BPW;
            fc    = 1 + j * (BPW + 2);
            waddr = s + BAW'(j);
            word  = mem[waddr];
            if (lane == 0) begin
                exp_ben[fc]   = 1'b1;
                exp_baddr[fc] = waddr;
            end
            wc = fc + 2 + lane;
            exp_wen[wc]   = 8'(1 << (k / dp));
            exp_waddr[wc] = 8'(int'(d) + (k % dp));
            exp_wdata[wc] = 8'(word >> (WGT_WIDTH * lane));
            last = wc;
        end
        exp_done_cyc = (exp_total == 0) ? 1 : last + 1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_ben"},   32'(bus.bram_en), 0);
        check({tag, "_baddr"}, 32'(bus.bram_addr), 0);
        check({tag, "_wen"},   32'(bus.bram_to_ram_w_en), 0);
        check({tag, "_waddr"}, 32'(bus.bram_to_ram_w_addr), 0);
        check({tag, "_wdata"}, 32'(bus.bram_to_ram_w_data), 0);
    endtask

    // restart_cyc: cycle in which a stray start is driven (-1 none, -2 random);
    // abort_cyc: cycle in which reset is pulsed mid-load (-1 none).
    task automatic run_load(input string name, input logic [BAW-1:0] s, input logic [7:0] d,
                            input logic [3:0] nc, input logic [8:0] dp,
                            input int restart_cyc, input int abort_cyc);
        int rs;
        string t;
        build_model(s, d, int'(nc), int'(dp));
        rs = (restart_cyc == -2) ? int'($urandom_range(1, exp_done_cyc)) : restart_cyc;
        @(negedge clk);
        src_base = s; dst_base = d; num_cols = nc; depth = dp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src_base = BAW'($urandom); dst_base = 8'($urandom); num_cols = 4'($urandom); depth = 9'($urandom);
        for (int cyc = 1; cyc <= exp_done_cyc + 3; cyc++) begin
            t = $sformatf("%s@%0d", name, cyc);
            check({t, "_busy"}, 32'(busy), 32'(exp_total > 0 && cyc < exp_done_cyc));
            check({t, "_done"}, 32'(done), 32'(cyc == exp_done_cyc));
            check({t, "_ben"},  32'(bus.bram_en), 32'(exp_ben[cyc]));
            if (exp_ben[cyc]) check({t, "_baddr"}, 32'(bus.bram_addr), 32'(exp_baddr[cyc]));
            check({t, "_wen"},  32'(bus.bram_to_ram_w_en), 32'(exp_wen[cyc]));
            if (exp_wen[cyc] != 0) begin
                check({t, "_waddr"}, 32'(bus.bram_to_ram_w_addr), 32'(exp_waddr[cyc]));
                check({t, "_wdata"}, 32'(bus.bram_to_ram_w_data), 32'(exp_wdata[cyc]));
            end
            if (cyc == abort_cyc) begin
                #2 reset = 1'b0;
                #1 check_idle_outputs({t, "_rst_async"});
                @(negedge clk);
                check_idle_outputs({t, "_rst_held"});
                reset = 1'b1;
                for (int k = 1; k <= 6; k++) begin
                    @(negedge clk);
                    check($sformatf("%s_post_rst%0d_done", name, k), 32'(done), 0);
                    check($sformatf("%s_post_rst%0d_wen", name, k), 32'(bus.bram_to_ram_w_en), 0);
                    check($sformatf("%s_post_rst%0d_ben", name, k), 32'(bus.bram_en), 0);
                end
                return;
            end
            if (cyc == rs) begin
                start = 1'b1;
                num_cols = 4'($urandom_range(1, 8)); depth = 9'($urandom_range(1, 5));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        bus.bram_rdata = '0;

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;

        mem[16'h10] = 32'h4433_2211;
        mem[16'h11] = 32'h8877_6655;
        run_load("basic", 16'h10, 8'd5, 4'd2, 9'd3, -1, -1);
        run_load("empty_d0", 16'h40, 8'd0, 4'd3, 9'd0, 1, -1);
        run_load("empty_n0", 16'h40, 8'd0, 4'd0, 9'd5, 1, -1);
        run_load("wrap", 16'h20, 8'd254, 4'd1, 9'd4, -1, -1);
        run_load("clamp", 16'h30, 8'd9, 4'd9, 9'd1, 4, -1);
        run_load("abort", 16'h10, 8'd5, 4'd2, 9'd3, -1, 4);
        run_load("after_abort", 16'h10, 8'd5, 4'd2, 9'd3, -1, -1);
        run_load("full", 16'h100, 8'd0, 4'd1, 9'd256, -1, -1);
        run_load("bram_wrap", 16'hFFFE, 8'd100, 4'd3, 9'd5, -2, -1);

        for (int r = 0; r < 12; r++) begin
            run_load($sformatf("rand%0d", r), BAW'($urandom), 8'($urandom),
                     4'($urandom_range(0, 15)), 9'($urandom_range(0, 30)),
                     (r % 2 == 0) ? -2 : -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/w_buffer_loader.md
Name: w_buffer_loader

Overview:
- Sequential loader between the on-chip BRAM (PS-written weight staging memory) and the weight buffer's per-column RAM write port.
- On a start pulse it reads packed weight words from BRAM and unpacks them one weight per cycle.
- Each weight goes to the correct column RAM as a one-hot write enable, row address and data.
- It fills `num_cols` × `depth` weights, column-major, then pulses `done`.

Parameters:
- `RAM_SIZE`, 256, entries per column RAM of the weight buffer.
- `ADDR_WIDTH`, clog2(RAM_SIZE), column RAM address width.
- `ARRAY_M`, 8, number of column RAMs.
- `WGT_WIDTH`, 8, weight width in bits.
- `BRAM_DATA_WIDTH`, 32, BRAM read-data width; must be a multiple of `WGT_WIDTH`.
- `BRAM_ADDR_WIDTH`, 16, BRAM word-address width.
- `BPW`, BRAM_DATA_WIDTH/WGT_WIDTH, weights per BRAM word (lanes).

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `src_base`  in  BRAM_ADDR_WIDTH  BRAM word address of the first weight.
- `dst_base`  in  ADDR_WIDTH  first row address in every column RAM.
- `num_cols`  in  clog2(ARRAY_M)+1  columns to fill; clamped to `ARRAY_M`.
- `depth`  in  ADDR_WIDTH+1  rows per column (0..RAM_SIZE).
- `busy`  out  1  high while a load is in progress.
- `done`  out  1  one-cycle pulse at load completion.
- `bram_en`  out  1  BRAM read enable.
- `bram_addr`  out  BRAM_ADDR_WIDTH  BRAM read word address.
- `bram_rdata`  in  BRAM_DATA_WIDTH  BRAM read data, valid 1 cycle after `bram_en`.
- `bram_to_ram_w_en`  out  ARRAY_M  one-hot column write enable.
- `bram_to_ram_w_addr`  out  ADDR_WIDTH  column RAM row address.
- `bram_to_ram_w_data`  out  WGT_WIDTH  weight to write.

Behaviour:
- Reset (`reset` = 0, asynchronous) forces:
  - FSM to IDLE;
  - `busy`, `done`, `bram_en`, `bram_to_ram_w_en` to 0;
  - `bram_addr`, `bram_to_ram_w_addr`, `bram_to_ram_w_data` and all counters/registers to 0.
- Reset mid-load aborts the load immediately: no further writes, no `done`.
- All outputs are registered.
- On `start` in IDLE, latch `src_base`, `dst_base`, `depth` and `ncol` = min(`num_cols`, ARRAY_M).
- Element ordering: element k = col*depth + row, for col 0..ncol-1 and row 0..depth-1.
  - k resides in word `src_base` + k/BPW, lane k%BPW.
  - Lane 0 = bits [WGT_WIDTH-1:0] and is written first.
  - Packing is continuous across column boundaries; a new column does not realign to a word.
- FSM states: IDLE, FETCH, WAIT, UNPACK, DONE.
- IDLE:
  - `start` with ncol = 0 or `depth` = 0 → DONE; no BRAM reads, no writes.
  - Otherwise → FETCH.
  - `busy` = 0.
- FETCH (1 cycle): `bram_en` = 1, `bram_addr` = current word address → WAIT.
- WAIT (1 cycle): `bram_en` = 0; capture `bram_rdata` into the word register; lane = 0 → UNPACK.
- UNPACK: one write per cycle.
  - `bram_to_ram_w_en` = one-hot bit col.
  - `bram_to_ram_w_addr` = (`dst_base` + row) mod RAM_SIZE, i.e. truncated to ADDR_WIDTH; wrap-around is allowed.
  - `bram_to_ram_w_data` = current lane.
  - Advance row; on row = depth-1, row ← 0 and col ← col+1.
  - Advance lane and element count.
  - If the last element was just written → DONE.
  - Else if lane = BPW-1 → word address +1, go to FETCH.
  - Else stay in UNPACK.
  - A partially used final word is legal; unused lanes are discarded.
- DONE (1 cycle): `done` = 1, `busy` = 0, then → IDLE.
- `busy` = 1 in FETCH, WAIT and UNPACK.
- `bram_to_ram_w_en` = 0 in every state except UNPACK.
- Timing, with `start` sampled at edge E0:
  - `bram_en` is high in cycle 1; first write in cycle 3.
  - Each subsequent word costs BPW+2 cycles.
  - `done` is high in the cycle after the last write.
- `start` while busy or in DONE is ignored (not queued).
- `bram_addr` wraps modulo 2^BRAM_ADDR_WIDTH.
- Inputs other than `start` are don't-care outside the start cycle.

Test Plan:
1. Basic load (ARRAY_M = 8, BPW = 4).
   - Stimulus: `num_cols` = 2, `depth` = 3, `src_base` = 0x10, `dst_base` = 5; mem[0x10] = 0x44332211, mem[0x11] = 0x88776655.
   - Writes, as (en, addr, data): (0x01,5,0x11), (0x01,6,0x22), (0x01,7,0x33), (0x02,5,0x44), (0x02,6,0x55), (0x02,7,0x66).
   - `bram_en` in cycles 1 (addr 0x10) and 7 (addr 0x11); writes in cycles 3-6 and 9-10; `done` in cycle 11; no further writes.
2. Empty load: `depth` = 0, `num_cols` = 3 → `done` in cycle 1, `busy` never high, no `bram_en`, no writes. Repeat with `num_cols` = 0: same result.
3. Address wrap: `num_cols` = 1, `depth` = 4, `dst_base` = 254 → addresses 254, 255, 0, 1, all with en = 0x01.
4. Clamp and ignore.
   - `num_cols` = 9, `depth` = 1 → exactly 8 writes, en 0x01 through 0x80 in order, 2 BRAM reads.
   - A second `start` asserted in cycle 4 has no effect.
5. Reset mid-operation: drop `reset` during UNPACK.
   - All outputs are 0 in the same cycle (asynchronous); no `done`.
   - After release, a fresh test-1 load completes exactly as in scenario 1.
6. Full depth: `depth` = 256, `num_cols` = 1, `dst_base` = 0 → 256 writes with addresses 0..255, 64 BRAM reads, `done` once.
